// File: rtl/mem_bus_ctrl.sv
// Bus controller between the core data bus and a synchronous word SRAM.
// One request at a time, fixed wait states, misaligned/out-of-range accesses answered without touching memory.
module mem_bus_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [31:0]           db_addr,
  input  logic [1:0]            db_accessType,
  input  logic [31:0]           db_dataOut,
  output logic [31:0]           db_dataIn,
  output logic                  db_ready,
  output logic                  db_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  mem_oe,
  output logic                  mem_we
);

  localparam logic [1:0] MEM_ACCESS_NONE = 2'b00;
  localparam logic [1:0] MEM_ACCESS_R    = 2'b01;
  localparam logic [1:0] MEM_ACCESS_W    = 2'b10;
  localparam logic [1:0] MEM_ACCESS_X    = 2'b11;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           data_q;
  logic [1:0]            kind_q;
  logic                  err_q;
  logic                  accept;
  logic                  req_err;

  // A new request is taken only when no access is in flight (IDLE or DONE).
  assign accept  = (state != ACCESS) && (db_accessType != MEM_ACCESS_NONE);
  assign req_err = (db_addr[1:0] != 2'b00) || ((db_addr >> (ADDR_WIDTH + 2)) != 32'd0);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_nxt = req_err ? DONE : ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data register is cleared on acceptance so writes and error responses return zero.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt     <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      data_q  <= 32'd0;
      kind_q  <= MEM_ACCESS_NONE;
      err_q   <= 1'b0;
    end else if (accept) begin
      cnt     <= WAIT_INIT;
      addr_q  <= db_addr[ADDR_WIDTH+1:2];
      wdata_q <= db_dataOut;
      data_q  <= 32'd0;
      kind_q  <= db_accessType;
      err_q   <= req_err;
    end else if (state == ACCESS) begin
      if (cnt == 4'd0) begin
        if (kind_q != MEM_ACCESS_W) begin
          data_q <= mem_rdata;
        end
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    db_ready  = 1'b0;
    db_err    = 1'b0;
    db_dataIn = 32'd0;
    mem_oe    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    case (state)
      ACCESS: begin
        mem_we = (kind_q == MEM_ACCESS_W);
        mem_oe = (kind_q == MEM_ACCESS_R) || (kind_q == MEM_ACCESS_X);
      end
      DONE: begin
        db_ready  = 1'b1;
        db_err    = err_q;
        db_dataIn = data_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: stimulus pushes expected responses, a negedge monitor pops and compares them.
module tb_mem_bus_ctrl;

  localparam logic [1:0] K_NONE = 2'b00;
  localparam logic [1:0] K_R    = 2'b01;
  localparam logic [1:0] K_W    = 2'b10;
  localparam logic [1:0] K_X    = 2'b11;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic [31:0] db_addr = 32'd0;
  logic [1:0]  db_accessType = K_NONE;
  logic [31:0] db_dataOut = 32'd0;
  logic [31:0] db_dataIn;
  logic        db_ready;
  logic        db_err;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_oe;
  logic        mem_we;

  logic [31:0] mem [0:15];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  mem_bus_ctrl #(.ADDR_WIDTH(16), .WAIT_CYCLES(2)) dut (
    .clk(clk), .res(res),
    .db_addr(db_addr), .db_accessType(db_accessType), .db_dataOut(db_dataOut),
    .db_dataIn(db_dataIn), .db_ready(db_ready), .db_err(db_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_oe(mem_oe), .mem_we(mem_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: preloaded while reset is held, written on mem_we.
  always @(posedge clk) begin
    if (!res) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + i;
      mem[0] <= 32'hA5A5_A5A5;
      mem[1] <= 32'h5A5A_0001;
      mem[4] <= 32'hDEAD_BEEF;
    end else if (mem_we) begin
      mem[mem_addr[3:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[3:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] kind, input logic [31:0] addr, input logic [31:0] wd);
    db_accessType = kind;
    db_addr       = addr;
    db_dataOut    = wd;
  endtask

  task automatic expect_resp(input int at, input logic [31:0] data, input logic err);
    exp_t e;
    e.cyc  = at;
    e.data = data;
    e.err  = err;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (db_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", {31'd0, db_ready}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_cycle", cyc, e.cyc);
        check("resp_data", db_dataIn, e.data);
        check("resp_err", {31'd0, db_err}, {31'd0, e.err});
      end
    end
    if (mem_oe || mem_we) check("strobes_exclusive", {31'd0, mem_oe & mem_we}, 32'd0);
  end

  initial begin
    int t;
    repeat (2) step();
    check("rst_ready", {31'd0, db_ready}, 32'd0);
    check("rst_err", {31'd0, db_err}, 32'd0);
    check("rst_dataIn", db_dataIn, 32'd0);
    check("rst_oe_we", {30'd0, mem_oe, mem_we}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    #2 res = 1'b1;
    repeat (2) step();

    // Aligned read of word 4
    t = cyc;
    drive(K_R, 32'h0000_0010, 32'd0);
    expect_resp(t + 3, 32'hDEAD_BEEF, 1'b0);
    step();
    drive(K_NONE, 32'd0, 32'd0);
    check("rd_oe_c1", {31'd0, mem_oe}, 32'd1);
    check("rd_we_c1", {31'd0, mem_we}, 32'd0);
    check("rd_addr_c1", {16'd0, mem_addr}, 32'd4);
    step();
    check("rd_oe_c2", {31'd0, mem_oe}, 32'd1);
    check("rd_addr_c2", {16'd0, mem_addr}, 32'd4);
    step();
    check("rd_oe_done", {31'd0, mem_oe}, 32'd0);
    repeat (2) step();

    // Write with inputs changed mid-access
    t = cyc;
    drive(K_W, 32'h0000_0020, 32'h1234_5678);
    expect_resp(t + 3, 32'd0, 1'b0);
    step();
    drive(K_NONE, 32'h0000_0030, 32'hFFFF_FFFF);
    check("wr_we_c1", {31'd0, mem_we}, 32'd1);
    check("wr_oe_c1", {31'd0, mem_oe}, 32'd0);
    check("wr_addr_c1", {16'd0, mem_addr}, 32'd8);
    check("wr_wdata_c1", mem_wdata, 32'h1234_5678);
    step();
    check("wr_we_c2", {31'd0, mem_we}, 32'd1);
    check("wr_addr_c2", {16'd0, mem_addr}, 32'd8);
    check("wr_wdata_c2", mem_wdata, 32'h1234_5678);
    step();
    check("wr_we_done", {31'd0, mem_we}, 32'd0);
    check("wr_mem8", mem[8], 32'h1234_5678);
    repeat (2) step();

    // Misaligned read
    t = cyc;
    drive(K_R, 32'h0000_0013, 32'd0);
    expect_resp(t + 1, 32'd0, 1'b1);
    step();
    drive(K_NONE, 32'd0, 32'd0);
    check("mis_no_strobe", {30'd0, mem_oe, mem_we}, 32'd0);
    repeat (2) step();

    // Out-of-range fetch
    t = cyc;
    drive(K_X, 32'h0004_0000, 32'd0);
    expect_resp(t + 1, 32'd0, 1'b1);
    step();
    drive(K_NONE, 32'd0, 32'd0);
    check("oor_no_strobe", {30'd0, mem_oe, mem_we}, 32'd0);
    repeat (2) step();

    // Back-to-back fetches, second presented in the DONE cycle
    t = cyc;
    drive(K_X, 32'h0000_0000, 32'd0);
    expect_resp(t + 3, 32'hA5A5_A5A5, 1'b0);
    step();
    drive(K_NONE, 32'd0, 32'd0);
    repeat (2) step();
    check("b2b_done_oe", {31'd0, mem_oe}, 32'd0);
    drive(K_X, 32'h0000_0004, 32'd0);
    expect_resp(t + 6, 32'h5A5A_0001, 1'b0);
    step();
    drive(K_NONE, 32'd0, 32'd0);
    check("b2b_oe2", {31'd0, mem_oe}, 32'd1);
    check("b2b_addr2", {16'd0, mem_addr}, 32'd1);
    repeat (4) step();

    // Dropped write still commits
    t = cyc;
    drive(K_W, 32'h0000_0008, 32'hCAFE_F00D);
    expect_resp(t + 3, 32'd0, 1'b0);
    step();
    drive(K_NONE, 32'd0, 32'd0);
    check("drop_we_c1", {31'd0, mem_we}, 32'd1);
    step();
    check("drop_we_c2", {31'd0, mem_we}, 32'd1);
    step();
    check("drop_we_done", {31'd0, mem_we}, 32'd0);
    repeat (2) step();
    check("drop_mem2", mem[2], 32'hCAFE_F00D);

    // Read back the earlier write
    t = cyc;
    drive(K_R, 32'h0000_0020, 32'd0);
    expect_resp(t + 3, 32'h1234_5678, 1'b0);
    step();
    drive(K_NONE, 32'd0, 32'd0);
    repeat (4) step();

    // Reset in the middle of a read
    drive(K_R, 32'h0000_0010, 32'd0);
    step();
    drive(K_NONE, 32'd0, 32'd0);
    check("rst_mid_oe_before", {31'd0, mem_oe}, 32'd1);
    #2 res = 1'b0;
    #1;
    check("rst_mid_oe", {31'd0, mem_oe}, 32'd0);
    check("rst_mid_we", {31'd0, mem_we}, 32'd0);
    check("rst_mid_ready", {31'd0, db_ready}, 32'd0);
    repeat (2) step();
    #2 res = 1'b1;
    repeat (6) step();
    check("post_rst_idle", {29'd0, mem_oe, mem_we, db_ready}, 32'd0);

    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory-side bus controller directly downstream of the CPU core's data bus.
- Accepts one db_* request (fetch, read or write) at a time and runs it against a synchronous-SRAM-style word memory with a fixed number of wait states.
- Returns db_ready plus read data to the core.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
- ADDR_WIDTH, 16, word-address width of the memory port; reachable byte range is 0 .. 4*2^ADDR_WIDTH-1.
- WAIT_CYCLES, 2, cycles the memory strobe is held per access; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  asynchronous active-low reset.
- db_addr  in  32  byte address from core.
- db_accessType  in  2  `MEM_ACCESS_T` request kind: `MEM_ACCESS_NONE`, `MEM_ACCESS_R`, `MEM_ACCESS_W` or `MEM_ACCESS_X`, as defined in DataBus.vh.
- db_dataOut  in  32  write data from core.
- db_dataIn  out  32  read data to core; valid while db_ready=1.
- db_ready  out  1  one-cycle completion pulse.
- db_err  out  1  qualifies db_ready: access was misaligned or out of range.
- mem_addr  out  ADDR_WIDTH  word address to memory.
- mem_wdata  out  32  write data to memory.
- mem_rdata  in  32  read data from memory; valid when mem_oe has been high for WAIT_CYCLES cycles.
- mem_oe  out  1  read strobe.
- mem_we  out  1  write strobe.

Behaviour:
- States:
  - IDLE: no access in progress.
  - ACCESS: strobes active, wait counter running.
  - DONE: completion cycle.
- Reset (res=0, asynchronous):
  - state=IDLE; wait counter=0; latched addr, data and kind registers=0.
  - db_dataIn=0, db_ready=0, db_err=0, mem_oe=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Request acceptance: in IDLE or DONE, if db_accessType != NONE, latch the following at the clock edge:
  - db_addr[ADDR_WIDTH+1:2] as the word address;
  - db_dataOut as write data;
  - the request kind;
  - err = (db_addr[1:0] != 0) or (db_addr[31:ADDR_WIDTH+2] != 0).
- Transitions after acceptance:
  - err=0: next state ACCESS, counter=WAIT_CYCLES-1.
  - err=1: next state DONE directly; no strobe is asserted.
- ACCESS:
  - mem_addr and mem_wdata come from the latched registers; they are stable for the whole access.
  - mem_oe=1 for R or X; mem_we=1 for W; never both.
  - Counter decrements each cycle.
  - At the edge where counter==0: capture mem_rdata into the data register (R or X only; W leaves it unchanged) and go to DONE.
- DONE:
  - db_ready=1 for exactly this cycle; db_err=latched err; db_dataIn=data register.
  - db_dataIn is 0 for W and for err responses.
  - If db_accessType != NONE in this cycle, it is accepted as a new request (back-to-back, no bubble). Otherwise go to IDLE.
- Latency:
  - Legal access: request present in cycle T while IDLE gives db_ready in cycle T+WAIT_CYCLES+1.
  - Error access: db_ready in cycle T+1.
- All outputs are registered or decoded from state only. There is no combinational path from db_* inputs to db_ready.
- A request dropped mid-access (db_accessType returns to NONE during ACCESS) is still completed: the write is committed and db_ready pulses anyway. Requests are never aborted.
- db_addr, db_dataOut and db_accessType changes during ACCESS are ignored.
- Reset asserted mid-access: strobes drop immediately (asynchronously); no completion pulse is issued after reset releases.
- Kind X is identical to R at this level.

Test Plan:
- WAIT_CYCLES=2, read: R @0x00000010 with mem_rdata at word 4 = 0xDEADBEEF -> mem_oe high 2 cycles with mem_addr=4; db_ready on cycle 3 with db_dataIn=0xDEADBEEF, db_err=0.
- Write: W @0x00000020, db_dataOut=0x12345678 -> mem_we high 2 cycles, mem_addr=8, mem_wdata=0x12345678, mem_oe=0; db_ready on cycle 3 with db_dataIn=0.
- Misaligned: R @0x00000013 -> no strobes; db_ready and db_err both high on cycle 1. Out-of-range: X @0x00040000 (ADDR_WIDTH=16) -> same response.
- Back-to-back: X @0 immediately followed by X @4 presented in the DONE cycle -> second access starts the next cycle; two db_ready pulses 3 cycles apart.
- Dropped request: W issued, then db_accessType=NONE after 1 cycle -> mem_we still held 2 cycles; db_ready pulses once.
- Reset: res low during ACCESS -> mem_oe, mem_we and db_ready are 0 immediately; after res returns high, with no new request the block stays IDLE with no pulse.
